// File: rtl/mul16_arb_pkg.sv
// mul16_arb_pkg: shared widths, ID-width helper and the result FIFO entry
// layout for the mul16 arbiter slice.
package mul16_arb_pkg;

  localparam int RES_W    = 32;
  localparam int OP_W     = 16;
  // Widest requester ID the design supports (N_REQ up to 8).
  localparam int ID_MAX_W = 3;

  // ID width for n requesters: max(1, clog2(n)).
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [RES_W-1:0]    data;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/mul16.sv
// mul16: pipelined 16x16 unsigned multiplier, 2-cycle latency, no reset,
// no handshake. Operands presented in cycle t appear on r in cycle t+2.
module mul16 (
  input  logic        clk,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] r
);

  logic [15:0] a_p1;
  logic [15:0] b_p1;
  logic [31:0] r_p2;

  // Stage 1 captures operands, stage 2 captures the exact 32-bit product.
  always_ff @(posedge clk) begin
    a_p1 <= a;
    b_p1 <= b;
    r_p2 <= {16'b0, a_p1} * {16'b0, b_p1};
  end

  assign r = r_p2;

endmodule

// File: rtl/mul16_arb_fifo.sv
// mul16_arb_fifo: synchronous first-word-fall-through FIFO of fifo_entry_t
// with an occupancy count. Push and pop may coincide at any count.
module mul16_arb_fifo
  import mul16_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  logic [ENTRY_W-1:0]          push_entry_i,
  input  logic                        pop_i,
  output logic [ENTRY_W-1:0]          head_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  fifo_entry_t                mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]             count_q, count_d;
  logic                       pop_ok;

  // A pop on an empty FIFO is ignored so the count can never underflow.
  assign pop_ok = pop_i && (count_q != '0);

  // Next pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state clears immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= fifo_entry_t'(push_entry_i);
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/mul16_arbiter.sv
// mul16_arbiter: shares one mul16 between N_REQ requesters with a credit
// check that reserves a result FIFO slot for every in-flight product.
// Results return in issue order, tagged with the requester ID.
// Build option: define MUL16_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins); otherwise round-robin starting after the last grant.
module mul16_arbiter
  import mul16_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*OP_W-1:0]   req_a,
  input  logic [N_REQ*OP_W-1:0]   req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [id_w(N_REQ)-1:0]  res_id,
  output logic [RES_W-1:0]        res_data,
  output logic                    busy
);

  localparam int ID_W = id_w(N_REQ);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              credit_ok;
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_id;
  logic              accept;
  logic [OP_W-1:0]   mul_a, mul_b;
  logic [RES_W-1:0]  mul_r;

  logic              vld_p1_q, vld_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic [ID_W-1:0]   id_p1_q, id_p1_d;
  logic [ID_W-1:0]   id_p2_q, id_p2_d;

  logic [CNT_W-1:0]  fifo_count;
  fifo_entry_t       push_entry;
  fifo_entry_t       head;
  logic [ID_MAX_W-1:0] unused_head_id;

`ifndef MUL16_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]   last_ptr_q, last_ptr_d;
  int                idx;
`endif

  // Grant selection: credit check, then priority search over req_valid.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    // Same-cycle pops are deliberately not credited.
    credit_ok = (int'(fifo_count) + int'(vld_p1_q) + int'(vld_p2_q)) < FIFO_DEPTH;
`ifdef MUL16_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_found && req_valid[k]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(k);
      end
    end
`else
    idx = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
`endif
    accept    = gnt_found && credit_ok && !rst;
    req_ready = '0;
    if (accept) req_ready[gnt_id] = 1'b1;
  end

  // Issue mux: granted operand slice into the multiplier, zeros otherwise.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        mul_a = req_a[i*OP_W +: OP_W];
        mul_b = req_b[i*OP_W +: OP_W];
      end
    end
  end

  mul16 u_mul16 (
    .clk (clk),
    .a   (mul_a),
    .b   (mul_b),
    .r   (mul_r)
  );

  // Tag pipeline next state, aligned with the two multiplier stages.
  always_comb begin
    vld_p1_d = accept;
    id_p1_d  = gnt_id;
    vld_p2_d = vld_p1_q;
    id_p2_d  = id_p1_q;
  end

`ifndef MUL16_ARB_FIXED_PRIO_EN
  // Round-robin pointer moves only on an accept.
  always_comb begin
    last_ptr_d = last_ptr_q;
    if (accept) last_ptr_d = gnt_id;
  end

  // Pointer resets to the last index so requester 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_ptr_q <= ID_W'(N_REQ - 1);
    else     last_ptr_q <= last_ptr_d;
  end
`endif

  // Stage p1/p2 valids: cleared on reset so stale products are never pushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // Stage p1/p2 IDs travel with the valids; meaningful only when valid.
  always_ff @(posedge clk) begin
    id_p1_q <= id_p1_d;
    id_p2_q <= id_p2_d;
  end

  // Stage p2 valid means mul_r holds this tag's product; push it.
  always_comb begin
    push_entry      = '0;
    push_entry.id   = ID_MAX_W'(id_p2_q);
    push_entry.data = mul_r;
  end

  mul16_arb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (vld_p2_q),
    .push_entry_i (push_entry),
    .pop_i        (res_valid && res_ready),
    .head_o       (head),
    .count_o      (fifo_count)
  );

  assign unused_head_id = head.id;

  // Head is masked when empty so the port reads zero after reset.
  assign res_valid = (fifo_count != '0);
  assign res_id    = res_valid ? head.id[ID_W-1:0] : '0;
  assign res_data  = res_valid ? head.data : '0;
  assign busy      = vld_p1_q || vld_p2_q || (fifo_count != '0);

endmodule

// File: tb/tb_mul16_arbiter.sv
// tb_mul16_arbiter: directed bench for mul16_arbiter with hand-computed
// expected grants and products.
module tb_mul16_arbiter;

  localparam int N_REQ      = 4;
  localparam int FIFO_DEPTH = 4;

  logic                  clk;
  logic                  rst;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*16-1:0]   req_a;
  logic [N_REQ*16-1:0]   req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [1:0]            res_id;
  logic [31:0]           res_data;
  logic                  busy;

  int tests_run;
  int tests_failed;
  int cyc;

  int          gq[$];
  int          gcyc[$];
  int          rid[$];
  logic [31:0] rdata[$];
  int          rcyc[$];

  mul16_arbiter #(
    .N_REQ      (N_REQ),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // A push into a full FIFO must never happen.
  always @(negedge clk) begin
    if (!rst && dut.vld_p2_q && (int'(dut.fifo_count) == FIFO_DEPTH))
      check("push_at_full", 1, 0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1 with inputs set; records accepts/pops then advances.
  task automatic tick();
    #1;
    check("ready_onehot0", 64'($onehot0(req_ready)), 1);
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        gq.push_back(i);
        gcyc.push_back(cyc);
      end
    end
    if (res_valid && res_ready) begin
      rid.push_back(int'(res_id));
      rdata.push_back(res_data);
      rcyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_logs();
    gq.delete(); gcyc.delete(); rid.delete(); rdata.delete(); rcyc.delete();
    cyc = 0;
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
  endtask

  logic [15:0] op_a [4] = '{16'h0003, 16'h0100, 16'hFFFF, 16'h0000};
  logic [15:0] op_b [4] = '{16'h0005, 16'h0100, 16'hFFFF, 16'hFFFF};
  logic [31:0] prod [4] = '{32'h0000000F, 32'h00010000, 32'hFFFE0001, 32'h00000000};
  int n3;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    rst          = 1'b1;
    req_valid    = '0;
    res_ready    = 1'b0;
    req_a        = '0;
    req_b        = '0;

    // Reset values while rst is held.
    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_id",    res_id,    0);
    check("rst_res_data",  res_data,  0);
    check("rst_busy",      busy,      0);

    // Single request from requester 2.
    reset_dut();
    res_ready         = 1'b1;
    req_a[47:32]      = 16'h1234;
    req_b[47:32]      = 16'h0010;
    req_valid         = 4'b0100;
    tick();
    req_valid = '0;
    repeat (6) tick();
    check("single_ngrant", gq.size(), 1);
    check("single_nres",   rq_size(), 1);
    if (gq.size() >= 1) check("single_gid", gq[0], 2);
    if (rid.size() >= 1 && gcyc.size() >= 1) begin
      check("single_id",      rid[0],   2);
      check("single_data",    rdata[0], 32'h00012340);
      check("single_latency", rcyc[0] - gcyc[0], 3);
    end
    check("single_busy_idle", busy, 0);

`ifdef MUL16_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 3 starves while requester 0 is valid.
    reset_dut();
    res_ready = 1'b1;
    req_valid = 4'b1001;
    repeat (8) tick();
    req_valid = '0;
    repeat (6) tick();
    n3 = 0;
    foreach (gq[k]) if (gq[k] == 3) n3++;
    check("fixed_ngrant", gq.size(), 8);
    check("fixed_req3",   n3,        0);
`else
    // All four requesters streaming: round-robin, 1 result per cycle.
    reset_dut();
    res_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*16 +: 16] = op_a[i];
      req_b[i*16 +: 16] = op_b[i];
    end
    req_valid = 4'b1111;
    repeat (8) tick();
    req_valid = '0;
    repeat (6) tick();
    check("rr_ngrant", gq.size(), 8);
    check("rr_nres",   rq_size(), 8);
    if (gq.size() == 8 && rid.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        check($sformatf("rr_gid%0d", k),   gq[k],    k % 4);
        check($sformatf("rr_gcyc%0d", k),  gcyc[k],  gcyc[0] + k);
        check($sformatf("rr_id%0d", k),    rid[k],   k % 4);
        check($sformatf("rr_data%0d", k),  rdata[k], prod[k % 4]);
        check($sformatf("rr_rcyc%0d", k),  rcyc[k],  gcyc[k] + 3);
      end
    end
`endif

    // Back-pressure: exactly FIFO_DEPTH accepts, then resume without loss.
    reset_dut();
    res_ready    = 1'b0;
    req_b[15:0]  = 16'h0100;
    req_valid    = 4'b0001;
    repeat (10) begin
      req_a[15:0] = 16'(gq.size() + 1);
      tick();
    end
    check("bp_naccept", gq.size(), FIFO_DEPTH);
    #1;
    check("bp_ready_low", req_ready, 0);
    check("bp_res_valid", res_valid, 1);
    check("bp_busy",      busy,      1);
    res_ready = 1'b1;
    for (int t = 0; t < 40 && gq.size() < 8; t++) begin
      req_a[15:0] = 16'(gq.size() + 1);
      tick();
    end
    check("bp_resume", gq.size() >= 8, 1);
    req_valid = '0;
    repeat (8) tick();
    check("bp_nres", rq_size(), gq.size());
    for (int k = 0; k < rdata.size(); k++) begin
      check($sformatf("bp_id%0d", k),   rid[k],   0);
      check($sformatf("bp_data%0d", k), rdata[k], 32'((k + 1) * 256));
    end

    // Reset with 2 products in flight and 2 results queued.
    reset_dut();
    res_ready    = 1'b0;
    req_a[15:0]  = 16'h0002;
    req_b[15:0]  = 16'h0002;
    req_valid    = 4'b0001;
    repeat (4) tick();
    check("mr_naccept", gq.size(), 4);
    check("mr_busy_pre", busy, 1);
    req_valid = '0;
    rst       = 1'b1;
    #1;
    check("mr_res_valid", res_valid, 0);
    check("mr_busy",      busy,      0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    res_ready = 1'b1;
    repeat (6) tick();
    check("mr_no_stale", rq_size(), 0);
    req_a[31:16] = 16'h0007;
    req_b[31:16] = 16'h0009;
    req_valid    = 4'b0010;
    tick();
    req_valid = '0;
    repeat (6) tick();
    check("mr_nres", rq_size(), 1);
    if (rid.size() >= 1) begin
      check("mr_id",   rid[0],   1);
      check("mr_data", rdata[0], 32'h0000003F);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  function automatic int rq_size();
    return rdata.size();
  endfunction

endmodule
